// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter FSM encoding, RGB565 colour constants and font geometry.
package lcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  localparam logic [15:0] COL_BG_DEFAULT = 16'hE73F;
  localparam logic [15:0] COL_BLACK      = 16'h0000;
  localparam logic [15:0] COL_WHITE      = 16'hFFFF;

  localparam int unsigned FONT_W_SMALL = 6;
  localparam int unsigned FONT_H_SMALL = 12;
  localparam int unsigned FONT_W_LARGE = 8;
  localparam int unsigned FONT_H_LARGE = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  always_comb begin
    int idx;
    valid     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    // Scan from the farthest candidate back so the one nearest rr_ptr is assigned last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % int'(N_REQ);
      if (req[idx]) begin
        valid     = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Round-robin arbiter sharing one ST7735 char-draw engine between display clients.
// Define ARB_TIMEOUT_EN to abort a character whose show_char_done never arrives.
module lcd_char_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_CLIENT = 3,
  parameter logic [19:0] TIMEOUT  = 20'd1000000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   init_done,
  input  logic [N_CLIENT-1:0]    cli_req,
  input  logic [7*N_CLIENT-1:0]  cli_ascii,
  input  logic [9*N_CLIENT-1:0]  cli_x,
  input  logic [9*N_CLIENT-1:0]  cli_y,
  input  logic [N_CLIENT-1:0]    cli_size,
  input  logic [16*N_CLIENT-1:0] cli_bg,
  input  logic [16*N_CLIENT-1:0] cli_fg,
  output logic [N_CLIENT-1:0]    cli_ack,
  output logic [N_CLIENT-1:0]    cli_err,
  input  logic                   show_char_done,
  output logic                   show_char_flag,
  output logic [6:0]             ascii_num,
  output logic [8:0]             start_x,
  output logic [8:0]             start_y,
  output logic                   en_size,
  output logic [15:0]            background_color,
  output logic [15:0]            front_color,
  output logic                   busy
);

  localparam int unsigned PtrW = (N_CLIENT > 1) ? $clog2(N_CLIENT) : 1;

  arb_state_e            state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       g_q, g_d;
  logic [PtrW-1:0]       pick_idx;
  logic                  pick_valid;
  logic [6:0]            ascii_q, ascii_d;
  logic [8:0]            x_q, x_d, y_q, y_d;
  logic                  size_q, size_d;
  logic [15:0]           bg_q, bg_d, fg_q, fg_d;
  logic                  flag_q, flag_d;
  logic [N_CLIENT-1:0]   ack_q, ack_d;
  logic [N_CLIENT-1:0]   g_onehot;

  rr_pick #(
    .N_REQ (N_CLIENT),
    .PTR_W (PtrW)
  ) u_rr_pick (
    .req       (cli_req),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  assign g_onehot = {{(N_CLIENT-1){1'b0}}, 1'b1} << g_q;

`ifdef ARB_TIMEOUT_EN
  logic [19:0]         cnt_q, cnt_d;
  logic [N_CLIENT-1:0] err_q, err_d;
  logic                timed_out;

  assign timed_out = (cnt_q == TIMEOUT - 20'd1);
  assign cli_err   = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign cli_err        = '0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    ascii_d  = ascii_q;
    x_d      = x_q;
    y_d      = y_q;
    size_d   = size_q;
    bg_d     = bg_q;
    fg_d     = fg_q;
    flag_d   = 1'b0;
    ack_d    = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (init_done && pick_valid) begin
          ascii_d  = cli_ascii[7*pick_idx +: 7];
          x_d      = cli_x[9*pick_idx +: 9];
          y_d      = cli_y[9*pick_idx +: 9];
          size_d   = cli_size[pick_idx];
          bg_d     = cli_bg[16*pick_idx +: 16];
          fg_d     = cli_fg[16*pick_idx +: 16];
          g_d      = pick_idx;
          rr_ptr_d = (32'(pick_idx) == N_CLIENT - 1) ? '0 : pick_idx + 1'b1;
          flag_d   = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = init_done ? StWait : StIdle;
      end
      StWait: begin
        // Losing init_done aborts silently; the engine is being re-initialised.
        if (!init_done) begin
          state_d = StIdle;
        end else if (show_char_done) begin
          ack_d   = g_onehot;
          state_d = StIdle;
`ifdef ARB_TIMEOUT_EN
        end else if (timed_out) begin
          err_d   = g_onehot;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 20'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      g_q      <= '0;
      ascii_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      size_q   <= 1'b1;
      bg_q     <= COL_BG_DEFAULT;
      fg_q     <= COL_BLACK;
      flag_q   <= 1'b0;
      ack_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      ascii_q  <= ascii_d;
      x_q      <= x_d;
      y_q      <= y_d;
      size_q   <= size_d;
      bg_q     <= bg_d;
      fg_q     <= fg_d;
      flag_q   <= flag_d;
      ack_q    <= ack_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign show_char_flag   = flag_q;
  assign cli_ack          = ack_q;
  assign ascii_num        = ascii_q;
  assign start_x          = x_q;
  assign start_y          = y_q;
  assign en_size          = size_q;
  assign background_color = bg_q;
  assign front_color      = fg_q;
  assign busy             = (state_q != StIdle);

endmodule
